// File: rtl/aes_sbox_if.sv
// Byte-lookup bus for the AES S-box: a qualified input byte and a qualified registered result.
interface aes_sbox_if;
   logic       in_valid;
   logic [7:0] in;
   logic       out_valid;
   logic [7:0] out;

   modport master (output in_valid, output in, input  out_valid, input  out);
   modport slave  (input  in_valid, input  in, output out_valid, output out);
endinterface

// File: rtl/aes_sbox.sv
// Forward AES SubBytes S-box, one byte per cycle; pure table decode into a result register.
module aes_sbox (
   input  logic        clk,
   input  logic        rst_n,
   aes_sbox_if.slave   bus
);

   // Row n holds S(16*n + 0) .. S(16*n + 15).
   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   logic [7:0] w_sub;
   logic [7:0] r_out;
   logic       r_valid;

   assign w_sub = SBOX[bus.in];

   // The result register only loads on a qualified byte, so downstream can hold-sample it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_out   <= 8'h00;
         r_valid <= 1'b0;
      end else begin
         r_valid <= bus.in_valid;
         if (bus.in_valid) begin
            r_out <= w_sub;
         end
      end
   end

   assign bus.out       = r_out;
   assign bus.out_valid = r_valid;

endmodule

// File: tb/tb_aes_sbox.sv
// Bench for aes_sbox: GF(2^8) inverse + affine reference model, per-cycle compare, directed literals.
module tb_aes_sbox;

   logic clk;
   logic rst_n;
   aes_sbox_if bus ();

   aes_sbox dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] exp_out   = 8'h00;
   logic       exp_valid = 1'b0;
   logic       model_live = 1'b0;

   // ---------------- reference model: S(x) = affine(inv(x)) over GF(2^8) mod 0x11B
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      logic [7:0] y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = xtime(x);
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] ginv(input logic [7:0] a);
      if (a == 8'h00) return 8'h00;
      for (int c = 1; c < 256; c++) begin
         if (gmul(a, 8'(c)) == 8'h01) return 8'(c);
      end
      return 8'h00;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] b, input int k);
      logic [15:0] t = {b, b};
      return 8'(t >> (8 - k));
   endfunction

   function automatic logic [7:0] sbox_ref(input logic [7:0] x);
      logic [7:0] b = ginv(x);
      return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model state follows the register rules at each active edge.
   always @(posedge clk) begin
      if (!rst_n) begin
         exp_out   = 8'h00;
         exp_valid = 1'b0;
      end else if (bus.in_valid) begin
         exp_out   = sbox_ref(bus.in);
         exp_valid = 1'b1;
      end else begin
         exp_valid = 1'b0;
      end
      model_live = 1'b1;
   end

   always @(negedge clk) begin
      if (model_live) begin
         chk("model_out_valid", {7'b0, bus.out_valid}, {7'b0, exp_valid});
         chk("model_out", bus.out, exp_out);
      end
   end

   // Inputs change on the falling edge; after the task returns, outputs reflect them.
   task automatic cyc(input logic rst, input logic vld, input logic [7:0] d);
      rst_n        = rst;
      bus.in_valid = vld;
      bus.in       = d;
      @(posedge clk);
      @(negedge clk);
   endtask

   logic [7:0] dir_in  [9] = '{8'h00, 8'h23, 8'h56, 8'ha3, 8'h4e, 8'h19, 8'hff, 8'hcc, 8'hdf};
   logic [7:0] dir_exp [9] = '{8'h63, 8'h26, 8'hb1, 8'h0a, 8'h2f, 8'hd4, 8'h16, 8'h4b, 8'h9e};

   initial begin
      int fixed_pts;
      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      bus.in       = 8'h00;

      // Pin the model against hand-known table entries.
      chk("ref_01", sbox_ref(8'h01), 8'h7c);
      chk("ref_10", sbox_ref(8'h10), 8'hca);
      chk("ref_80", sbox_ref(8'h80), 8'hcd);
      chk("ref_53", sbox_ref(8'h53), 8'hed);
      chk("ref_00", sbox_ref(8'h00), 8'h63);

      // Reset holds outputs at zero even with a valid byte present.
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         cyc(1'b0, 1'b1, 8'h53);
         chk("rst_out", bus.out, 8'h00);
         chk("rst_valid", {7'b0, bus.out_valid}, 8'h00);
      end
      cyc(1'b1, 1'b1, 8'h53);
      chk("post_rst_53", bus.out, 8'hed);
      chk("post_rst_valid", {7'b0, bus.out_valid}, 8'h01);

      // Directed vectors, back to back.
      for (int i = 0; i < 9; i++) begin
         cyc(1'b1, 1'b1, dir_in[i]);
         chk("dir_out", bus.out, dir_exp[i]);
         chk("dir_valid", {7'b0, bus.out_valid}, 8'h01);
      end

      // Hold: result stays, valid drops after one cycle.
      cyc(1'b1, 1'b1, 8'h19);
      chk("hold_first", bus.out, 8'hd4);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 1'b0, 8'($urandom));
         chk("hold_out", bus.out, 8'hd4);
         chk("hold_valid", {7'b0, bus.out_valid}, 8'h00);
      end

      // Reset mid-stream discards the in-flight byte.
      cyc(1'b1, 1'b1, 8'ha3);
      chk("mid_a3", bus.out, 8'h0a);
      cyc(1'b0, 1'b1, 8'hff);
      chk("mid_rst_out", bus.out, 8'h00);
      chk("mid_rst_valid", {7'b0, bus.out_valid}, 8'h00);
      cyc(1'b1, 1'b0, 8'h00);
      chk("mid_no_ff_out", bus.out, 8'h00);
      chk("mid_no_ff_valid", {7'b0, bus.out_valid}, 8'h00);

      // Exhaustive sweep; the per-cycle compare checks every code.
      fixed_pts = 0;
      for (int i = 0; i < 256; i++) begin
         cyc(1'b1, 1'b1, 8'(i));
         if (bus.out == 8'(i)) fixed_pts++;
      end
      chk("no_fixed_points", 8'(fixed_pts), 8'h00);

      // Randomised traffic with occasional resets.
      for (int i = 0; i < 2000; i++) begin
         cyc(($urandom_range(0, 39) != 0), ($urandom_range(0, 3) != 0), 8'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
